// File: rtl/spike_rate_encoder.sv
// Rate-coded spike generator: an LFSR-driven Bernoulli spike train whose firing
// probability tracks an 8-bit intensity, with a refractory hold-off after each spike.
module spike_rate_encoder #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_intensity,
  input  logic [7:0] i_num_steps,
  input  logic [7:0] i_tref,
  output logic       o_spike_out,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_step_count,
  output logic [7:0] o_spike_count
);

  localparam int unsigned CW = 8;
  localparam int unsigned LW = 16;
  localparam logic [LW-1:0] TAPS = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state,       w_state_nxt;
  logic [LW-1:0]   r_lfsr,        w_lfsr_nxt;
  logic [CW-1:0]   r_intensity,   w_intensity_nxt;
  logic [CW-1:0]   r_num_steps,   w_num_steps_nxt;
  logic [CW-1:0]   r_tref,        w_tref_nxt;
  logic [CW-1:0]   r_refr,        w_refr_nxt;
  logic [CW-1:0]   r_step_count,  w_step_count_nxt;
  logic [CW-1:0]   r_spike_count, w_spike_count_nxt;
  logic            r_spike_out,   w_spike_out_nxt;
  logic            r_busy,        w_busy_nxt;
  logic            r_done,        w_done_nxt;

  logic [LW-1:0]   w_lfsr_adv;
  logic            w_cand;
  logic [CW-1:0]   w_step_inc;

  // Galois right-shift LFSR step and spike candidate from the current low byte
  assign w_lfsr_adv = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : LW'(0));
  assign w_cand     = (r_lfsr[CW-1:0] < r_intensity) || (r_intensity == 8'hFF);
  assign w_step_inc = CW'(r_step_count + CW'(1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_lfsr        <= SEED;
      r_intensity   <= '0;
      r_num_steps   <= '0;
      r_tref        <= '0;
      r_refr        <= '0;
      r_step_count  <= '0;
      r_spike_count <= '0;
      r_spike_out   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_lfsr        <= w_lfsr_nxt;
      r_intensity   <= w_intensity_nxt;
      r_num_steps   <= w_num_steps_nxt;
      r_tref        <= w_tref_nxt;
      r_refr        <= w_refr_nxt;
      r_step_count  <= w_step_count_nxt;
      r_spike_count <= w_spike_count_nxt;
      r_spike_out   <= w_spike_out_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_lfsr_nxt        = r_lfsr;
    w_intensity_nxt   = r_intensity;
    w_num_steps_nxt   = r_num_steps;
    w_tref_nxt        = r_tref;
    w_refr_nxt        = r_refr;
    w_step_count_nxt  = r_step_count;
    w_spike_count_nxt = r_spike_count;
    w_spike_out_nxt   = r_spike_out;

    case (r_state)
      S_IDLE: begin
        w_spike_out_nxt = 1'b0;
        if (i_start) begin
          w_intensity_nxt   = i_intensity;
          w_num_steps_nxt   = i_num_steps;
          w_tref_nxt        = i_tref;
          w_refr_nxt        = '0;
          w_step_count_nxt  = '0;
          w_spike_count_nxt = '0;
          w_lfsr_nxt        = SEED;
          w_state_nxt       = (i_num_steps == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // LFSR advances every timestep, refractory or not
        w_lfsr_nxt       = w_lfsr_adv;
        w_step_count_nxt = w_step_inc;
        if (r_refr != '0) begin
          w_spike_out_nxt = 1'b0;
          w_refr_nxt      = CW'(r_refr - CW'(1));
        end else begin
          w_spike_out_nxt = w_cand;
          if (w_cand) begin
            w_spike_count_nxt = CW'(r_spike_count + CW'(1));
            w_refr_nxt        = r_tref;
          end
        end
        if (w_step_inc == r_num_steps) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_spike_out_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
      default: begin
        w_spike_out_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  assign o_spike_out   = r_spike_out;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_step_count  = r_step_count;
  assign o_spike_count = r_spike_count;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Self-checking bench for spike_rate_encoder: directed corner bursts plus random
// bursts compared against a step-by-step arithmetic model of the spike rules.
module tb_spike_rate_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] intensity;
  logic [7:0] num_steps;
  logic [7:0] tref;
  logic       spike_out;
  logic       busy;
  logic       done;
  logic [7:0] step_count;
  logic [7:0] spike_count;

  int passed = 0;
  int total  = 0;

  logic       obs_spk  [0:255];
  logic       obs_done [0:255];
  logic       obs_busy [0:255];
  logic [7:0] obs_step [0:255];
  logic       idle_spk, idle_busy, idle_done;
  logic [7:0] idle_step, idle_scnt;

  bit         exp_spk  [0:255];
  int         exp_cnt;

  spike_rate_encoder #(.SEED(16'hACE1)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_intensity  (intensity),
    .i_num_steps  (num_steps),
    .i_tref       (tref),
    .o_spike_out  (spike_out),
    .o_busy       (busy),
    .o_done       (done),
    .o_step_count (step_count),
    .o_spike_count(spike_count)
  );

  always #5 clk = ~clk;

  // Reference: walk the burst one timestep at a time with plain integer arithmetic
  task automatic model_burst(input int inten, input int n, input int tr);
    int lfsr, refr;
    bit cand, s;
    lfsr = 'hACE1; refr = 0; exp_cnt = 0;
    for (int k = 1; k <= n; k++) begin
      cand = ((lfsr % 256) < inten) || (inten == 255);
      if (refr > 0) begin
        s = 0; refr = refr - 1;
      end else begin
        s = cand;
        if (s) begin exp_cnt++; refr = tr; end
      end
      exp_spk[k] = s;
      lfsr = (lfsr / 2) ^ (((lfsr % 2) == 1) ? 'hB400 : 0);
    end
  endtask

  // Drives one burst from IDLE and records outputs after E0 .. EN and after EN+1
  task automatic capture_burst(input logic [7:0] inten, input logic [7:0] n,
                               input logic [7:0] tr, input bit hold);
    intensity = inten; num_steps = n; tref = tr; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    intensity = 8'($urandom); num_steps = 8'($urandom); tref = 8'($urandom);
    obs_spk[0] = spike_out; obs_done[0] = done; obs_busy[0] = busy; obs_step[0] = step_count;
    for (int k = 1; k <= int'(n); k++) begin
      @(posedge clk); #1;
      obs_spk[k] = spike_out; obs_done[k] = done; obs_busy[k] = busy; obs_step[k] = step_count;
    end
    @(posedge clk); #1;
    start = 1'b0;
    idle_spk = spike_out; idle_busy = busy; idle_done = done;
    idle_step = step_count; idle_scnt = spike_count;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; intensity = '0; num_steps = '0; tref = '0;
    #3;
    total++;
    if ({spike_out, busy, done, step_count, spike_count} !== 19'd0)
      $display("FAIL reset_outputs got spk=%b busy=%b done=%b step=%0d scnt=%0d want all 0",
               spike_out, busy, done, step_count, spike_count);
    else passed++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({busy, done, spike_out} !== 3'b000)
      $display("FAIL idle_hold got busy=%b done=%b spk=%b want 000", busy, done, spike_out);
    else passed++;
  endtask

  task automatic test_zero_steps;
    capture_burst(8'hFF, 8'd0, 8'd0, 1'b0);
    total++;
    if ({obs_done[0], obs_busy[0], obs_spk[0]} !== 3'b110)
      $display("FAIL zero_steps_done got done=%b busy=%b spk=%b want 110",
               obs_done[0], obs_busy[0], obs_spk[0]);
    else passed++;
    total++;
    if ({idle_done, idle_busy, idle_step, idle_scnt} !== 18'd0)
      $display("FAIL zero_steps_after got done=%b busy=%b step=%0d scnt=%0d want 0",
               idle_done, idle_busy, idle_step, idle_scnt);
    else passed++;
  endtask

  task automatic test_intensity_zero;
    int ones;
    int dones;
    capture_burst(8'd0, 8'd10, 8'd0, 1'b0);
    ones = 0; dones = 0;
    for (int k = 1; k <= 10; k++) begin
      ones += int'(obs_spk[k]);
      dones += int'(obs_done[k]);
    end
    total++;
    if (ones !== 0) $display("FAIL int0_spikes got %0d want 0", ones); else passed++;
    total++;
    if (dones !== 1 || obs_done[10] !== 1'b1 || idle_done !== 1'b0)
      $display("FAIL int0_done got pulses=%0d last=%b after=%b want 1 1 0", dones, obs_done[10], idle_done);
    else passed++;
    total++;
    if ({idle_step, idle_scnt} !== {8'd10, 8'd0})
      $display("FAIL int0_counts got step=%0d scnt=%0d want 10 0", idle_step, idle_scnt);
    else passed++;
  endtask

  task automatic test_full_tref0;
    logic [7:0] trace;
    capture_burst(8'hFF, 8'd8, 8'd0, 1'b0);
    for (int k = 1; k <= 8; k++) trace[k-1] = obs_spk[k];
    total++;
    if (trace !== 8'hFF) $display("FAIL full_tref0_trace got %b want 11111111", trace); else passed++;
    total++;
    if (idle_scnt !== 8'd8 || idle_spk !== 1'b0)
      $display("FAIL full_tref0_count got scnt=%0d spk=%b want 8 0", idle_scnt, idle_spk);
    else passed++;
  endtask

  task automatic test_full_tref2;
    logic [8:0] trace;
    capture_burst(8'hFF, 8'd9, 8'd2, 1'b0);
    for (int k = 1; k <= 9; k++) trace[k-1] = obs_spk[k];
    total++;
    if (trace !== 9'b001001001) $display("FAIL full_tref2_trace got %b want 001001001", trace); else passed++;
    total++;
    if (idle_scnt !== 8'd3) $display("FAIL full_tref2_count got %0d want 3", idle_scnt); else passed++;
  endtask

  task automatic test_seed_boundary;
    capture_burst(8'hE2, 8'd1, 8'd0, 1'b0);
    total++;
    if ({obs_spk[1], obs_done[1], idle_scnt} !== {1'b1, 1'b1, 8'd1})
      $display("FAIL seed_e2 got spk=%b done=%b scnt=%0d want 1 1 1", obs_spk[1], obs_done[1], idle_scnt);
    else passed++;
    capture_burst(8'hE1, 8'd1, 8'd0, 1'b0);
    total++;
    if ({obs_spk[1], idle_scnt} !== {1'b0, 8'd0})
      $display("FAIL seed_e1 got spk=%b scnt=%0d want 0 0", obs_spk[1], idle_scnt);
    else passed++;
  endtask

  task automatic test_random;
    int inten, n, tr, bad, bad_k;
    for (int b = 0; b < 8; b++) begin
      inten = int'($urandom_range(0, 255));
      n     = int'($urandom_range(1, 60));
      tr    = int'($urandom_range(0, 4));
      model_burst(inten, n, tr);
      capture_burst(8'(inten), 8'(n), 8'(tr), 1'b0);
      bad = 0; bad_k = 0;
      for (int k = 1; k <= n; k++) begin
        if (obs_spk[k] !== exp_spk[k] || obs_step[k] !== 8'(k) || obs_busy[k] !== 1'b1 ||
            obs_done[k] !== (k == n)) begin
          if (bad == 0) bad_k = k;
          bad++;
        end
      end
      total++;
      if (bad !== 0)
        $display("FAIL random_trace burst=%0d int=%0d n=%0d tref=%0d step=%0d got spk=%b step=%0d done=%b want spk=%b step=%0d",
                 b, inten, n, tr, bad_k, obs_spk[bad_k], obs_step[bad_k], obs_done[bad_k], exp_spk[bad_k], bad_k);
      else passed++;
      total++;
      if ({idle_scnt, idle_step, idle_busy, idle_done, idle_spk} !== {8'(exp_cnt), 8'(n), 3'b000})
        $display("FAIL random_final burst=%0d got scnt=%0d step=%0d busy=%b done=%b spk=%b want %0d %0d 0 0 0",
                 b, idle_scnt, idle_step, idle_busy, idle_done, idle_spk, exp_cnt, n);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_burst;
    int dones, bad;
    intensity = 8'd100; num_steps = 8'd20; tref = 8'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1 dones += int'(done);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({spike_out, busy, done, step_count, spike_count} !== 19'd0)
      $display("FAIL midreset_outputs got spk=%b busy=%b done=%b step=%0d scnt=%0d want all 0",
               spike_out, busy, done, step_count, spike_count);
    else passed++;
    @(posedge clk); #1 dones += int'(done);
    reset = 1'b0;
    @(posedge clk); #1 dones += int'(done);
    total++;
    if (dones !== 0) $display("FAIL midreset_no_done got %0d pulses want 0", dones); else passed++;
    model_burst(100, 20, 1);
    capture_burst(8'd100, 8'd20, 8'd1, 1'b0);
    bad = 0;
    for (int k = 1; k <= 20; k++) if (obs_spk[k] !== exp_spk[k]) bad++;
    total++;
    if (bad !== 0 || idle_scnt !== 8'(exp_cnt))
      $display("FAIL midreset_rerun got %0d bad steps scnt=%0d want 0 bad scnt=%0d", bad, idle_scnt, exp_cnt);
    else passed++;
  endtask

  task automatic test_start_held;
    int bad, dones;
    model_burst(180, 12, 0);
    capture_burst(8'd180, 8'd12, 8'd0, 1'b1);
    bad = 0; dones = 0;
    for (int k = 1; k <= 12; k++) begin
      if (obs_spk[k] !== exp_spk[k] || obs_step[k] !== 8'(k)) bad++;
      dones += int'(obs_done[k]);
    end
    total++;
    if (bad !== 0 || dones !== 1)
      $display("FAIL start_held_trace got %0d bad steps %0d done pulses want 0 1", bad, dones);
    else passed++;
    total++;
    if ({idle_busy, idle_step, idle_scnt} !== {1'b0, 8'd12, 8'(exp_cnt)})
      $display("FAIL start_held_final got busy=%b step=%0d scnt=%0d want 0 12 %0d",
               idle_busy, idle_step, idle_scnt, exp_cnt);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({busy, step_count, spike_count} !== {1'b0, 8'd12, 8'(exp_cnt)})
      $display("FAIL idle_counts_hold got busy=%b step=%0d scnt=%0d want 0 12 %0d",
               busy, step_count, spike_count, exp_cnt);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_zero_steps;
    test_intensity_zero;
    test_full_tref0;
    test_full_tref2;
    test_seed_boundary;
    test_random;
    test_reset_mid_burst;
    test_start_held;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spike_rate_encoder.md
SPIKE_RATE_ENCODER -- requirements
Module: spike_rate_encoder

Interface
REQ-001 Parameter: SEED, 16'hACE1, nonzero LFSR reload value applied at reset and at every accepted start.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new encoding burst; sampled only in IDLE.
REQ-005 intensity  input  8  stimulus value, unsigned; higher value gives higher spike probability.
REQ-006 num_steps  input  8  burst length in timesteps, 0..255.
REQ-007 tref  input  8  refractory length in timesteps after each emitted spike.
REQ-008 spike_out  output  1  registered spike for the most recent timestep, one cycle wide.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  one-cycle pulse marking burst completion.
REQ-011 step_count  output  8  timesteps completed in the current or last burst.
REQ-012 spike_count  output  8  spikes emitted in the current or last burst.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE, with done = (state==DONE) and busy = (state!=IDLE).
REQ-014 IDLE with start=1 at an edge SHALL latch intensity, num_steps and tref, clear step_count, spike_count and the refractory counter, load the LFSR with SEED, and go to RUN, or to DONE if num_steps==0.
REQ-015 IDLE with start=0 SHALL hold all registers, with spike_out=0.
REQ-016 start SHALL be ignored in RUN and DONE, and latched inputs SHALL NOT change mid-burst.
REQ-017 Each RUN edge SHALL be one timestep: evaluate the spike from the current LFSR value, advance the LFSR, and increment step_count.
REQ-018 LFSR: 16-bit Galois, right shift; next = (lfsr>>1) XOR (lfsr[0] ? 16'hB400 : 0); it advances on every RUN edge, including refractory steps.
REQ-019 Spike candidate SHALL be (lfsr[7:0] < intensity) OR (intensity==8'hFF), so intensity 0 never fires and 255 always fires.
REQ-020 If the refractory counter is >0, the step SHALL emit no spike and the counter SHALL decrement by 1.
REQ-021 Otherwise spike_out SHALL take the candidate value; on a spike, spike_count increments and the refractory counter loads the latched tref (tref=0 gives no suppression).
REQ-022 The RUN edge that makes step_count equal num_steps SHALL move the FSM to DONE, and the last step's spike_out SHALL be visible during the DONE cycle.
REQ-023 DONE SHALL last exactly one cycle and then return to IDLE with spike_out cleared to 0.
REQ-024 After DONE, step_count and spike_count SHALL hold their values until the next accepted start.
REQ-025 Timing: start accepted at edge E0 gives spikes at edges E1..EN, done high for the cycle after EN, and the earliest next start accepted at edge EN+2.
REQ-026 Widths: counters are 8-bit and cannot overflow because num_steps is at most 255, so no wrap handling is required.

Reset
REQ-027 While reset=1, registers SHALL immediately take: state=IDLE, spike_out=0, step_count=0, spike_count=0, refractory counter=0, LFSR=SEED; busy and done are therefore 0.
REQ-028 Reset mid-burst SHALL abort the burst with no done pulse, and a following start SHALL reproduce the identical spike sequence.

Verification
REQ-029 num_steps=0, start -> DONE the next cycle, one done pulse, no spike, step_count=0, spike_count=0.
REQ-030 intensity=0, num_steps=10 -> spike_out 0 for all 10 steps, step_count=10, spike_count=0, done one cycle after step 10.
REQ-031 intensity=255, tref=0, num_steps=8 -> spike_out high 8 consecutive cycles, spike_count=8.
REQ-032 intensity=255, tref=2, num_steps=9 -> spikes at steps 1, 4 and 7 only, spike_count=3.
REQ-033 SEED=16'hACE1, num_steps=1: intensity=8'hE2 -> step 1 spikes (low byte 0xE1 < 0xE2); intensity=8'hE1 -> no spike.
REQ-034 Reset pulsed during RUN at step 5, then start again with the same inputs -> all outputs 0 after reset, no done during the aborted burst, and the new spike trace bit-identical to a clean run; start held high in RUN or DONE does not restart the burst.
